// File: rtl/wbi2csequencer_if.sv
// rtl/wbi2csequencer_if.sv - CPU control bus, I2C-master bus and interrupt bundle for wbi2csequencer
interface wbi2csequencer_if #(
  parameter int AW = 6
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [3:0]    i_wb_addr;
  logic [31:0]   i_wb_data;
  logic          o_wb_ack;
  logic          o_wb_stall;
  logic [31:0]   o_wb_data;
  logic          o_m_cyc;
  logic          o_m_stb;
  logic          o_m_we;
  logic [AW-1:0] o_m_addr;
  logic [31:0]   o_m_data;
  logic [3:0]    o_m_sel;
  logic          i_m_ack;
  logic          i_m_stall;
  logic [31:0]   i_m_data;
  logic          o_int;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_m_ack, i_m_stall, i_m_data,
    output o_wb_ack, o_wb_stall, o_wb_data, o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_m_data,
           o_m_sel, o_int
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_m_ack, i_m_stall, i_m_data,
    input  o_wb_ack, o_wb_stall, o_wb_data, o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_m_data,
           o_m_sel, o_int
  );
endinterface

// File: rtl/wbi2csequencer.sv
// rtl/wbi2csequencer.sv - replays up to 8 I2C CMD words into an I2C master, polling status between them
// Optional feature: define I2CSEQ_TIMEOUT_EN to bound status polls per command to TIMEOUT.
module wbi2csequencer #(
  parameter int SETTLE   = 4,
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 65535
) (
  input logic           i_clk,
  input logic           i_rst,
  wbi2csequencer_if.slave bus
);
  // One width fits both the wait counter and the optional poll counter.
  localparam int MAXA = (SETTLE > POLL_GAP) ? SETTLE : POLL_GAP;
  localparam int MAXC = (MAXA > TIMEOUT) ? MAXA : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR, S_WAIT, S_RD, S_NEXT, S_DONE, S_RSTWR
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   table_q [8];
  logic [31:0]   period_q, per_cnt, rd_mux;
  logic          per_arm, periodic, err, stb_done, int_q;
  logic [2:0]    idx, last;
  logic [CW-1:0] cnt;
  logic          busy, wb_req, ctrl_wr, abort_req, start_req, per_fire;
  logic          in_acc, m_ack, poll_busy, to_hit;

  assign busy      = (state != S_IDLE);
  assign wb_req    = bus.i_wb_cyc && bus.i_wb_stb;
  assign ctrl_wr   = wb_req && bus.i_wb_we && (bus.i_wb_addr == 4'd0);
  assign abort_req = ctrl_wr && bus.i_wb_data[29];
  assign start_req = ctrl_wr && bus.i_wb_data[31] && !bus.i_wb_data[29] && !busy;
  assign per_fire  = per_arm && (per_cnt <= 32'd1);
  assign in_acc    = (state == S_WR) || (state == S_RD) || (state == S_RSTWR);
  assign m_ack     = in_acc && bus.i_m_ack;
  assign poll_busy = bus.i_m_data[31];

`ifdef I2CSEQ_TIMEOUT_EN
  logic [CW-1:0] poll_cnt;
  assign to_hit = (state == S_RD) && m_ack && poll_busy && (int'(poll_cnt) + 1 >= TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (i_rst || state == S_WR) poll_cnt <= '0;
    else if (state == S_RD && m_ack) poll_cnt <= poll_cnt + CW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  assign bus.o_wb_stall = 1'b0;
  assign bus.o_m_addr   = '0;
  assign bus.o_m_sel    = 4'hf;
  assign bus.o_int      = int_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.o_m_cyc  = 1'b0;
    bus.o_m_stb  = 1'b0;
    bus.o_m_we   = 1'b0;
    bus.o_m_data = table_q[idx];
    case (state)
      S_IDLE:  if (start_req || per_fire) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (table_q[idx][6:0] == 7'd0) ? S_NEXT : S_WR;
      S_WR: begin
        bus.o_m_cyc = 1'b1;
        bus.o_m_stb = !stb_done;
        bus.o_m_we  = 1'b1;
        if (m_ack) state_nxt = S_WAIT;
      end
      S_WAIT:  if (cnt == '0) state_nxt = S_RD;
      S_RD: begin
        bus.o_m_cyc = 1'b1;
        bus.o_m_stb = !stb_done;
        if (m_ack) begin
          if (to_hit)         state_nxt = S_RSTWR;
          else if (poll_busy) state_nxt = S_WAIT;
          else                state_nxt = S_NEXT;
        end
      end
      S_NEXT:  state_nxt = (idx == last) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      S_RSTWR: begin
        bus.o_m_cyc  = 1'b1;
        bus.o_m_stb  = !stb_done;
        bus.o_m_we   = 1'b1;
        bus.o_m_data = 32'h8000_0000;
        if (m_ack) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req) state_nxt = S_IDLE;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.i_wb_addr)
      4'd0:    rd_mux = {busy, err, 13'h0, periodic, 13'h0, idx};
      4'd1:    rd_mux = period_q;
      default: if (bus.i_wb_addr[3]) rd_mux = table_q[bus.i_wb_addr[2:0]];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wb_req && bus.i_wb_we && bus.i_wb_addr[3] && !busy)
      table_q[bus.i_wb_addr[2:0]] <= bus.i_wb_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err           <= 1'b0;
      periodic      <= 1'b0;
      idx           <= '0;
      last          <= '0;
      period_q      <= '0;
      per_cnt       <= '0;
      per_arm       <= 1'b0;
      cnt           <= '0;
      stb_done      <= 1'b0;
      int_q         <= 1'b0;
      bus.o_wb_ack  <= 1'b0;
      bus.o_wb_data <= '0;
    end else begin
      bus.o_wb_ack <= wb_req;
      if (wb_req && !bus.i_wb_we) bus.o_wb_data <= rd_mux;
      int_q <= abort_req || (state == S_DONE);
      // stb stays low after acceptance until the ack of the same access arrives
      stb_done <= in_acc && !bus.i_m_ack && (stb_done || !bus.i_m_stall);

      if (ctrl_wr) begin
        if (bus.i_wb_data[30]) err <= 1'b0;
        if (!busy) begin
          periodic <= bus.i_wb_data[16];
          last     <= bus.i_wb_data[2:0];
        end
      end
      if (wb_req && bus.i_wb_we && bus.i_wb_addr == 4'd1) period_q <= bus.i_wb_data;
      if (state == S_RD && m_ack && !poll_busy && bus.i_m_data[30]) err <= 1'b1;
      if (to_hit) err <= 1'b1;

      if (state == S_IDLE && state_nxt == S_LOAD)      idx <= '0;
      else if (state == S_NEXT && state_nxt == S_LOAD) idx <= idx + 3'd1;

      if (state == S_WR && m_ack)                    cnt <= CW'(SETTLE);
      else if (state == S_RD && m_ack && poll_busy)  cnt <= CW'(POLL_GAP);
      else if (state == S_WAIT && cnt != '0)         cnt <= cnt - CW'(1);

      if (state == S_DONE) begin
        per_arm <= periodic && (period_q != 32'd0);
        per_cnt <= period_q;
      end else if (state == S_IDLE && per_arm) begin
        if (per_fire) per_arm <= 1'b0;
        else          per_cnt <= per_cnt - 32'd1;
      end
      if (start_req || abort_req) per_arm <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wbi2csequencer.sv
// tb/tb_wbi2csequencer.sv - self-checking bench with a behavioural I2C-master model and scoreboard
module tb_wbi2csequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wbi2csequencer_if #(.AW(6)) bus();
  wbi2csequencer #(.SETTLE(4), .POLL_GAP(16), .TIMEOUT(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc_n = 0, int_cnt = 0, int_cyc = 0, wstart_cyc = 0;
  logic prev_w = 1'b0;
  logic [31:0] wr_log[$];
  int busy_q[$];
  bit errf_q[$];
  int rd_cnt = 0, addr_bad = 0, busy_left = 0, m_dly = 0;
  bit err_cur = 0, m_pend = 0;
  logic [31:0] m_resp = '0;

  typedef struct { bit we; logic [3:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;
  vec_t vt[$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (bus.o_int) begin int_cnt++; int_cyc = cyc_n; end
    if (bus.o_m_cyc && bus.o_m_we && !prev_w) wstart_cyc = cyc_n;
    prev_w = bus.o_m_cyc && bus.o_m_we;
  end

  // I2C master model: random stall, ack 0..2 clocks after acceptance, busy for a queued poll count
  always @(negedge clk) begin
    bus.i_m_ack   = 1'b0;
    bus.i_m_stall = 1'b0;
    bus.i_m_data  = $urandom;
    if (!bus.o_m_cyc) m_pend = 0;
    if (m_pend) begin
      if (m_dly == 0) begin bus.i_m_ack = 1'b1; bus.i_m_data = m_resp; m_pend = 0; end
      else m_dly--;
    end else if (bus.o_m_cyc && bus.o_m_stb) begin
      if ($urandom_range(0, 3) == 0) bus.i_m_stall = 1'b1;
      else begin
        int d;
        if (bus.o_m_addr != 6'd0 || bus.o_m_sel != 4'hf) addr_bad++;
        if (bus.o_m_we) begin
          wr_log.push_back(bus.o_m_data);
          m_resp = 32'h0;
          if (bus.o_m_data == 32'h8000_0000) begin busy_left = 0; err_cur = 0; end
          else begin
            busy_left = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
            err_cur   = (errf_q.size() > 0) ? errf_q.pop_front() : 1'b0;
          end
        end else begin
          rd_cnt++;
          if (busy_left > 0) begin m_resp = 32'h8000_0000; busy_left--; end
          else m_resp = err_cur ? 32'h4000_0000 : 32'h0;
        end
        d = $urandom_range(0, 2);
        if (d == 0) begin bus.i_m_ack = 1'b1; bus.i_m_data = m_resp; end
        else begin m_pend = 1; m_dly = d - 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = we; bus.i_wb_addr = a; bus.i_wb_data = d;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    chk($sformatf("wb_ack a=%0d", a), {31'b0, bus.o_wb_ack}, 32'd1);
    rd = bus.o_wb_data;
  endtask

  task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, a, d, unused_rd);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'h0, rd);
    chk(name, rd, exp);
  endtask

  task automatic clear_model();
    wr_log.delete(); busy_q.delete(); errf_q.delete();
    rd_cnt = 0; addr_bad = 0;
  endtask

  task automatic start_wait(input logic [31:0] ctrl, input string name);
    int target = int_cnt + 1;
    int n = 0;
    wb_wr(4'd0, ctrl);
    while (int_cnt < target && n < 20000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk({name, " int_pulses"}, int_cnt, target);
  endtask

  task automatic chk_writes(input string name, input logic [31:0] exp[$]);
    chk({name, " write_count"}, wr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
      chk($sformatf("%s write[%0d]", name, i), wr_log[i], exp[i]);
    chk({name, " bad_addr_sel"}, addr_bad, 0);
  endtask

  initial begin
    logic [31:0] expw[$];
    logic [31:0] tbl[8];
    int n, hi, base;

    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {27'b0, bus.o_m_cyc, bus.o_m_stb, bus.o_m_we, bus.o_int, bus.o_wb_ack}, 32'd0);
    rst = 1'b0;

    vt.push_back('{0, 4'd0,  32'h0,         32'h0});
    vt.push_back('{1, 4'd8,  32'h00A0_1004, 32'h0});
    vt.push_back('{0, 4'd8,  32'h0,         32'h00A0_1004});
    vt.push_back('{1, 4'd9,  32'h1234_5680, 32'h0});
    vt.push_back('{0, 4'd9,  32'h0,         32'h1234_5680});
    vt.push_back('{1, 4'd10, 32'h00B0_2003, 32'h0});
    vt.push_back('{0, 4'd10, 32'h0,         32'h00B0_2003});
    vt.push_back('{1, 4'd1,  32'd100,       32'h0});
    vt.push_back('{0, 4'd1,  32'h0,         32'd100});
    vt.push_back('{0, 4'd2,  32'h0,         32'h0});
    vt.push_back('{0, 4'd7,  32'h0,         32'h0});
    vt.push_back('{1, 4'd0,  32'h0001_0005, 32'h0});
    vt.push_back('{0, 4'd0,  32'h0,         32'h0001_0000});
    vt.push_back('{1, 4'd0,  32'h0,         32'h0});
    vt.push_back('{0, 4'd0,  32'h0,         32'h0});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) wb_wr(vt[i].a, vt[i].d);
      else rd_chk($sformatf("vec%0d rd a=%0d", i, vt[i].a), vt[i].a, vt[i].exp);
    end

    // single entry, busy for 3 polls
    clear_model(); busy_q.push_back(3); errf_q.push_back(0);
    start_wait(32'h8000_0000, "t1");
    expw = '{32'h00A0_1004};
    chk_writes("t1", expw);
    chk("t1 reads", rd_cnt, 4);
    rd_chk("t1 ctrl", 4'd0, 32'h0);

    // zero-count entry skipped
    clear_model();
    start_wait(32'h8000_0002, "t2");
    expw = '{32'h00A0_1004, 32'h00B0_2003};
    chk_writes("t2", expw);
    rd_chk("t2 ctrl", 4'd0, 32'h0000_0002);

    // error bit on entry0's final poll
    wb_wr(4'd9, 32'h1234_5681);
    clear_model(); busy_q = '{1, 0}; errf_q = '{1, 0};
    start_wait(32'h8000_0001, "t3");
    expw = '{32'h00A0_1004, 32'h1234_5681};
    chk_writes("t3", expw);
    chk("t3 reads", rd_cnt, 3);
    rd_chk("t3 ctrl err", 4'd0, 32'h4000_0001);
    wb_wr(4'd0, 32'h4000_0000);
    rd_chk("t3 ctrl cleared", 4'd0, 32'h0000_0001);

    // periodic restart
    clear_model();
    wb_wr(4'd1, 32'd100);
    base = int_cnt;
    start_wait(32'h8001_0000, "t4 first");
    hi = int_cyc;
    n = 0;
    while (wstart_cyc <= hi && n < 400) begin @(negedge clk); n++; end
    n_chk++;
    if (wstart_cyc - hi < 98 || wstart_cyc - hi > 102) begin
      n_err++;
      $display("FAIL t4 restart_delay: got %0d expected 98..102", wstart_cyc - hi);
    end
    n = 0;
    while (int_cnt < base + 2 && n < 2000) begin @(negedge clk); n++; end
    chk("t4 second int", int_cnt, base + 2);
    wb_wr(4'd0, 32'h2000_0000);
    hi = wstart_cyc;
    repeat (150) @(negedge clk);
    chk("t4 stopped", wstart_cyc, hi);

    // abort while polling
    clear_model(); busy_q.push_back(1000);
    wb_wr(4'd0, 32'h8000_0000);
    n = 0;
    while (!(wr_log.size() >= 1 && !bus.o_m_cyc) && n < 300) begin @(negedge clk); n++; end
    chk("t5 reached wait", wr_log.size(), 1);
    wb_wr(4'd8, 32'hDEAD_BEE1);
    rd_chk("t5 ctrl busy", 4'd0, 32'h8000_0000);
    wb_wr(4'd0, 32'h2000_0000);
    chk("t5 cyc/int after abort", {30'b0, bus.o_m_cyc, bus.o_int}, 32'd1);
    hi = 0;
    repeat (40) begin @(negedge clk); if (bus.o_m_cyc) hi++; end
    chk("t5 no access after abort", hi, 0);
    rd_chk("t5 busy write ignored", 4'd8, 32'h00A0_1004);
    wb_wr(4'd8, 32'h0000_1111);
    rd_chk("t5 table write accepted", 4'd8, 32'h0000_1111);

    // reset during WR
    clear_model();
    wb_wr(4'd0, 32'h8000_0000);
    n = 0;
    while (!(bus.o_m_cyc && bus.o_m_we) && n < 50) begin @(negedge clk); n++; end
    chk("t6 in WR", {31'b0, bus.o_m_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 outputs after reset", {27'b0, bus.o_m_cyc, bus.o_m_stb, bus.o_m_we, bus.o_int, bus.o_wb_ack}, 32'd0);
    rst = 1'b0;
    rd_chk("t6 ctrl", 4'd0, 32'h0);
    rd_chk("t6 table kept", 4'd8, 32'h0000_1111);

    // randomized tables against the scoreboard
    for (int it = 0; it < 5; it++) begin
      logic [2:0] L;
      int exp_rd;
      bit exp_err;
      L = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
        tbl[i] = $urandom;
        if ($urandom_range(0, 3) == 0) tbl[i][6:0] = 7'd0;
        else if (tbl[i][6:0] == 7'd0) tbl[i][0] = 1'b1;
        wb_wr(4'(8 + i), tbl[i]);
      end
      clear_model(); expw.delete(); exp_rd = 0; exp_err = 0;
      for (int i = 0; i <= int'(L); i++) begin
        if (tbl[i][6:0] != 7'd0) begin
          int b;
          bit e;
          b = $urandom_range(0, 2);
          e = ($urandom_range(0, 3) == 0);
          expw.push_back(tbl[i]); busy_q.push_back(b); errf_q.push_back(e);
          exp_rd += b + 1; exp_err |= e;
        end
      end
      start_wait({29'h1800_0000, L}, $sformatf("rnd%0d", it));
      chk_writes($sformatf("rnd%0d", it), expw);
      chk($sformatf("rnd%0d reads", it), rd_cnt, exp_rd);
      rd_chk($sformatf("rnd%0d ctrl", it), 4'd0, {1'b0, exp_err, 27'h0, L});
    end

`ifdef I2CSEQ_TIMEOUT_EN
    wb_wr(4'd8, 32'h00A0_1004);
    clear_model(); busy_q.push_back(100);
    start_wait(32'hC000_0000, "t7");
    expw = '{32'h00A0_1004, 32'h8000_0000};
    chk_writes("t7", expw);
    chk("t7 reads", rd_cnt, 4);
    rd_chk("t7 ctrl", 4'd0, 32'h4000_0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
